// File: rtl/snn_lif_net.sv
// Two-layer leaky integrate-and-fire network: N_IN hidden LIF neurons feed a
// registered weighted adder that drives one output LIF neuron with a spike counter.
module snn_lif_net #(
  parameter int N_IN       = 8,
  parameter int W          = 8,
  parameter int WEIGHT_W   = 4,
  parameter int LEAK_SHIFT = 3,
  parameter int IN_GAIN    = 32,
  parameter int H_THR_RST  = 64,
  parameter int O_THR_RST  = 16,
  parameter int REFRAC     = 2,
  parameter int SUB_RESET  = 0,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [N_IN-1:0]             in_spike,
  input  logic                        cfg_we,
  input  logic [$clog2(N_IN+2)-1:0]   cfg_addr,
  input  logic [W-1:0]                cfg_data,
  output logic [N_IN-1:0]             hid_spike,
  output logic                        spike_out,
  output logic [W-1:0]                state_out,
  output logic [CNT_W-1:0]            spike_cnt
);

  localparam int AW    = $clog2(N_IN + 2);
  localparam int SUM_W = WEIGHT_W + $clog2(N_IN);
  localparam int RW    = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  localparam logic [AW-1:0]       ADDR_HTHR = AW'(N_IN);
  localparam logic [AW-1:0]       ADDR_OTHR = AW'(N_IN + 1);
  localparam logic [W-1:0]        U_ZERO    = {W{1'b0}};
  localparam logic [W-1:0]        U_MAX     = {W{1'b1}};
  localparam logic [W-1:0]        GAIN_V    = W'(IN_GAIN);
  localparam logic [W-1:0]        H_THR_V   = W'(H_THR_RST);
  localparam logic [W-1:0]        O_THR_V   = W'(O_THR_RST);
  localparam logic [RW-1:0]       R_ZERO    = {RW{1'b0}};
  localparam logic [RW-1:0]       R_ONE     = RW'(1'b1);
  localparam logic [RW-1:0]       REFRAC_V  = RW'(REFRAC);
  localparam logic [WEIGHT_W-1:0] W_RST     = WEIGHT_W'(1'b1);
  localparam logic [SUM_W-1:0]    SUM_ZERO  = {SUM_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1'b1);

  typedef struct packed {
    logic          spike;
    logic [W-1:0]  u;
    logic [RW-1:0] r;
  } lif_t;

  // Shared neuron rule: fire beats refractory beats integrate; the integrate
  // path adds at W+1 bits so an overflow clamps to the top of the range.
  function automatic lif_t lif_step(input logic [W-1:0]  u,
                                    input logic [RW-1:0] r,
                                    input logic [W-1:0]  thr,
                                    input logic [W-1:0]  amt);
    lif_t         nx;
    logic [W-1:0] leaked;
    logic [W:0]   acc;
    leaked = u - (u >> LEAK_SHIFT);
    acc    = {1'b0, leaked} + {1'b0, amt};
    if ((r == R_ZERO) && (u >= thr)) begin
      nx.spike = 1'b1;
      nx.u     = (SUB_RESET != 0) ? (u - thr) : U_ZERO;
      nx.r     = REFRAC_V;
    end else if (r != R_ZERO) begin
      nx.spike = 1'b0;
      nx.u     = leaked;
      nx.r     = r - R_ONE;
    end else begin
      nx.spike = 1'b0;
      nx.u     = acc[W] ? U_MAX : acc[W-1:0];
      nx.r     = r;
    end
    return nx;
  endfunction

  logic [N_IN-1:0][WEIGHT_W-1:0] w_r;
  logic [W-1:0]                  h_thr_r;
  logic [W-1:0]                  o_thr_r;
  logic [N_IN-1:0][W-1:0]        h_mem_r;
  logic [N_IN-1:0][RW-1:0]       h_ref_r;
  logic [N_IN-1:0]               hid_spike_r;
  logic [SUM_W-1:0]              sum_q_r;
  logic [W-1:0]                  o_mem_r;
  logic [RW-1:0]                 o_ref_r;
  logic                          spike_out_r;
  logic [CNT_W-1:0]              cnt_r;

  logic [N_IN-1:0]               w_we_s;
  logic                          h_thr_we_s;
  logic                          o_thr_we_s;
  logic [SUM_W-1:0]              sum_s;
  lif_t                          h_nx_s [N_IN];
  lif_t                          o_nx_s;

  // Config address decode; anything past the output threshold matches nothing.
  always_comb begin
    w_we_s     = {N_IN{1'b0}};
    h_thr_we_s = 1'b0;
    o_thr_we_s = 1'b0;
    if (cfg_we) begin
      for (int i = 0; i < N_IN; i++) begin
        if (cfg_addr == AW'(i)) begin
          w_we_s[i] = 1'b1;
        end else begin
          w_we_s[i] = 1'b0;
        end
      end
      h_thr_we_s = (cfg_addr == ADDR_HTHR);
      o_thr_we_s = (cfg_addr == ADDR_OTHR);
    end else begin
      w_we_s     = {N_IN{1'b0}};
      h_thr_we_s = 1'b0;
      o_thr_we_s = 1'b0;
    end
  end

  // Config registers ignore en so the network can be programmed while frozen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) begin
        w_r[i] <= W_RST;
      end
      h_thr_r <= H_THR_V;
      o_thr_r <= O_THR_V;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (w_we_s[i]) begin
          w_r[i] <= cfg_data[WEIGHT_W-1:0];
        end
      end
      if (h_thr_we_s) begin
        h_thr_r <= cfg_data;
      end
      if (o_thr_we_s) begin
        o_thr_r <= cfg_data;
      end
    end
  end

  // Next-state for every neuron and the weighted sum of the registered hidden spikes.
  always_comb begin
    sum_s = SUM_ZERO;
    for (int i = 0; i < N_IN; i++) begin
      h_nx_s[i] = lif_step(h_mem_r[i], h_ref_r[i], h_thr_r,
                           in_spike[i] ? GAIN_V : U_ZERO);
      if (hid_spike_r[i]) begin
        sum_s = sum_s + SUM_W'(w_r[i]);
      end else begin
        sum_s = sum_s;
      end
    end
    o_nx_s = lif_step(o_mem_r, o_ref_r, o_thr_r, W'(sum_q_r));
  end

  // Hidden layer state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_mem_r     <= {(N_IN*W){1'b0}};
      h_ref_r     <= {(N_IN*RW){1'b0}};
      hid_spike_r <= {N_IN{1'b0}};
    end else if (en) begin
      for (int i = 0; i < N_IN; i++) begin
        h_mem_r[i]     <= h_nx_s[i].u;
        h_ref_r[i]     <= h_nx_s[i].r;
        hid_spike_r[i] <= h_nx_s[i].spike;
      end
    end
  end

  // Adder stage, output neuron and saturating spike counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q_r     <= SUM_ZERO;
      o_mem_r     <= U_ZERO;
      o_ref_r     <= R_ZERO;
      spike_out_r <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
    end else if (en) begin
      sum_q_r     <= sum_s;
      o_mem_r     <= o_nx_s.u;
      o_ref_r     <= o_nx_s.r;
      spike_out_r <= o_nx_s.spike;
      if (o_nx_s.spike && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign hid_spike = hid_spike_r;
  assign spike_out = spike_out_r;
  assign state_out = o_mem_r;
  assign spike_cnt = cnt_r;

endmodule

// File: tb/tb_snn_lif_net.sv
// Directed-vector bench for snn_lif_net: three parameter variants share one
// stimulus bus, each scenario task checks the instance it targets.
module tb_snn_lif_net;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] in_spike;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [7:0] cfg_data;

  logic [7:0]  a_hid, b_hid, c_hid;
  logic        a_spk, b_spk, c_spk;
  logic [7:0]  a_state, b_state, c_state;
  logic [15:0] a_cnt, b_cnt;
  logic [1:0]  c_cnt;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  snn_lif_net dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .in_spike(in_spike),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .hid_spike(a_hid), .spike_out(a_spk), .state_out(a_state), .spike_cnt(a_cnt)
  );

  snn_lif_net #(.SUB_RESET(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .in_spike(in_spike),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .hid_spike(b_hid), .spike_out(b_spk), .state_out(b_state), .spike_cnt(b_cnt)
  );

  snn_lif_net #(.REFRAC(0), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .in_spike(in_spike),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .hid_spike(c_hid), .spike_out(c_spk), .state_out(c_state), .spike_cnt(c_cnt)
  );

  // Hand-computed trajectories, index 0 = first edge after reset release.
  logic [7:0] s_u   [7]  = '{8'd32, 8'd60, 8'd85, 8'd0, 8'd0, 8'd0, 8'd32};
  logic [7:0] s_hid [7]  = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
  logic [7:0] p_state [20] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd8, 8'd7, 8'd7, 8'd7, 8'd7,
                               8'd7, 8'd15, 8'd14, 8'd13, 8'd12, 8'd11, 8'd10, 8'd17, 8'd0, 8'd0};
  logic [6:0] p_sum [20] = '{7'd0, 7'd0, 7'd0, 7'd0, 7'd8, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0,
                             7'd8, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd8, 7'd0, 7'd0, 7'd0};

  task tick;
    @(posedge clk);
    #1;
  endtask

  task do_reset;
    rst_n = 1'b0; en = 1'b1; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 8'd0; in_spike = 8'h00;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task cfg_write(input logic [3:0] addr, input logic [7:0] data);
    en = 1'b0; cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
    tick;
    cfg_we = 1'b0;
  endtask

  task test_reset;
    do_reset;
    vecs++; if (a_hid !== 8'h00) begin $display("FAIL reset_hid: got %h want 00", a_hid); errs++; end
    vecs++; if (a_spk !== 1'b0) begin $display("FAIL reset_spk: got %b want 0", a_spk); errs++; end
    vecs++; if (a_state !== 8'd0) begin $display("FAIL reset_state: got %0d want 0", a_state); errs++; end
    vecs++; if (a_cnt !== 16'd0) begin $display("FAIL reset_cnt: got %0d want 0", a_cnt); errs++; end
    cfg_write(4'd0, 8'd9);
    cfg_write(4'd8, 8'd10);
    en = 1'b1; in_spike = 8'hFF;
    tick; tick; tick;
    vecs++; if (dut_a.sum_q_r !== 7'd16) begin $display("FAIL prog_sum: got %0d want 16", dut_a.sum_q_r); errs++; end
    tick;
    vecs++; if (a_state !== 8'd16) begin $display("FAIL prog_state: got %0d want 16", a_state); errs++; end
    tick;
    vecs++; if (a_spk !== 1'b1) begin $display("FAIL prog_spk: got %b want 1", a_spk); errs++; end
    vecs++; if (a_cnt !== 16'd1) begin $display("FAIL prog_cnt: got %0d want 1", a_cnt); errs++; end
    rst_n = 1'b0; en = 1'b0;
    tick;
    rst_n = 1'b1; en = 1'b1;
    vecs++; if (a_spk !== 1'b0) begin $display("FAIL midreset_spk: got %b want 0", a_spk); errs++; end
    vecs++; if (a_cnt !== 16'd0) begin $display("FAIL midreset_cnt: got %0d want 0", a_cnt); errs++; end
    vecs++; if (a_hid !== 8'h00) begin $display("FAIL midreset_hid: got %h want 00", a_hid); errs++; end
    vecs++; if (dut_a.h_mem_r[0] !== 8'd0) begin $display("FAIL midreset_u0: got %0d want 0", dut_a.h_mem_r[0]); errs++; end
  endtask

  task test_single;
    do_reset;
    in_spike = 8'h01;
    for (int e = 0; e < 7; e++) begin
      tick;
      vecs++;
      if (dut_a.h_mem_r[0] !== s_u[e]) begin
        $display("FAIL single_u0 e%0d: got %0d want %0d", e + 1, dut_a.h_mem_r[0], s_u[e]); errs++;
      end
      vecs++;
      if (a_hid !== s_hid[e]) begin
        $display("FAIL single_hid e%0d: got %h want %h", e + 1, a_hid, s_hid[e]); errs++;
      end
    end
  endtask

  task test_output_path;
    do_reset;
    in_spike = 8'hFF;
    for (int e = 0; e < 20; e++) begin
      tick;
      vecs++;
      if (a_state !== p_state[e]) begin
        $display("FAIL out_state e%0d: got %0d want %0d", e + 1, a_state, p_state[e]); errs++;
      end
      vecs++;
      if (dut_a.sum_q_r !== p_sum[e]) begin
        $display("FAIL out_sum e%0d: got %0d want %0d", e + 1, dut_a.sum_q_r, p_sum[e]); errs++;
      end
      vecs++;
      if (a_hid !== ((e == 3 || e == 9 || e == 15) ? 8'hFF : 8'h00)) begin
        $display("FAIL out_hid e%0d: got %h", e + 1, a_hid); errs++;
      end
      vecs++;
      if (a_spk !== (e == 18)) begin
        $display("FAIL out_spk e%0d: got %b want %b", e + 1, a_spk, (e == 18)); errs++;
      end
      vecs++;
      if (a_cnt !== ((e >= 18) ? 16'd1 : 16'd0)) begin
        $display("FAIL out_cnt e%0d: got %0d", e + 1, a_cnt); errs++;
      end
    end
  endtask

  task test_cfg_timing;
    do_reset;
    in_spike = 8'h01;
    tick; tick; tick;
    cfg_we = 1'b1; cfg_addr = 4'd8; cfg_data = 8'd200;
    tick;
    vecs++; if (a_hid !== 8'h01) begin $display("FAIL cfg_oldthr_hid: got %h want 01", a_hid); errs++; end
    cfg_addr = 4'd13; cfg_data = 8'd0;
    tick;
    cfg_we = 1'b0;
    tick; tick; tick; tick;
    vecs++; if (dut_a.h_mem_r[0] !== 8'd85) begin $display("FAIL cfg_u9: got %0d want 85", dut_a.h_mem_r[0]); errs++; end
    vecs++; if (a_hid !== 8'h00) begin $display("FAIL cfg_oor_hid: got %h want 00", a_hid); errs++; end
    tick;
    vecs++; if (a_hid !== 8'h00) begin $display("FAIL cfg_newthr_hid: got %h want 00", a_hid); errs++; end
    vecs++; if (dut_a.h_mem_r[0] !== 8'd107) begin $display("FAIL cfg_u10: got %0d want 107", dut_a.h_mem_r[0]); errs++; end
  endtask

  task test_enable;
    do_reset;
    in_spike = 8'h01;
    tick; tick; tick; tick;
    vecs++; if (a_hid !== 8'h01) begin $display("FAIL en_pre_hid: got %h want 01", a_hid); errs++; end
    en = 1'b0; in_spike = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      tick;
      vecs++; if (a_hid !== 8'h01) begin $display("FAIL en_hold_hid c%0d: got %h want 01", c, a_hid); errs++; end
      vecs++; if (dut_a.h_mem_r[1] !== 8'd0) begin $display("FAIL en_hold_u1 c%0d: got %0d want 0", c, dut_a.h_mem_r[1]); errs++; end
      vecs++; if (dut_a.sum_q_r !== 7'd0) begin $display("FAIL en_hold_sum c%0d: got %0d want 0", c, dut_a.sum_q_r); errs++; end
    end
    en = 1'b1; in_spike = 8'h01;
    tick;
    vecs++; if (a_hid !== 8'h00) begin $display("FAIL en_res_hid: got %h want 00", a_hid); errs++; end
    vecs++; if (dut_a.sum_q_r !== 7'd1) begin $display("FAIL en_res_sum: got %0d want 1", dut_a.sum_q_r); errs++; end
    tick;
    vecs++; if (a_state !== 8'd1) begin $display("FAIL en_res_state: got %0d want 1", a_state); errs++; end
    tick;
    vecs++; if (dut_a.h_mem_r[0] !== 8'd32) begin $display("FAIL en_res_u0: got %0d want 32", dut_a.h_mem_r[0]); errs++; end
  endtask

  task test_sub_reset;
    do_reset;
    in_spike = 8'h01;
    tick; tick; tick;
    vecs++; if (dut_b.h_mem_r[0] !== 8'd85) begin $display("FAIL sub_u3: got %0d want 85", dut_b.h_mem_r[0]); errs++; end
    tick;
    vecs++; if (b_hid !== 8'h01) begin $display("FAIL sub_hid: got %h want 01", b_hid); errs++; end
    vecs++; if (dut_b.h_mem_r[0] !== 8'd21) begin $display("FAIL sub_u4: got %0d want 21", dut_b.h_mem_r[0]); errs++; end
    tick;
    vecs++; if (dut_b.h_mem_r[0] !== 8'd19) begin $display("FAIL sub_u5: got %0d want 19", dut_b.h_mem_r[0]); errs++; end
    tick; tick;
    vecs++; if (dut_b.h_mem_r[0] !== 8'd47) begin $display("FAIL sub_u7: got %0d want 47", dut_b.h_mem_r[0]); errs++; end
  endtask

  task test_saturation;
    do_reset;
    for (int i = 0; i < 8; i++) cfg_write(4'(i), 8'd15);
    cfg_write(4'd8, 8'd0);
    cfg_write(4'd9, 8'd255);
    en = 1'b1; in_spike = 8'h00;
    tick;
    vecs++; if (c_hid !== 8'hFF) begin $display("FAIL sat_hid: got %h want ff", c_hid); errs++; end
    tick;
    vecs++; if (dut_c.sum_q_r !== 7'd120) begin $display("FAIL sat_sum: got %0d want 120", dut_c.sum_q_r); errs++; end
    tick;
    vecs++; if (c_state !== 8'd120) begin $display("FAIL sat_u3: got %0d want 120", c_state); errs++; end
    tick;
    vecs++; if (c_state !== 8'd225) begin $display("FAIL sat_u4: got %0d want 225", c_state); errs++; end
    tick;
    vecs++; if (c_state !== 8'd255) begin $display("FAIL sat_u5: got %0d want 255", c_state); errs++; end
    vecs++; if (c_spk !== 1'b0) begin $display("FAIL sat_spk5: got %b want 0", c_spk); errs++; end
    tick;
    vecs++; if (c_spk !== 1'b1) begin $display("FAIL sat_spk6: got %b want 1", c_spk); errs++; end
    vecs++; if (c_state !== 8'd0) begin $display("FAIL sat_u6: got %0d want 0", c_state); errs++; end
  endtask

  task test_counter_sat;
    do_reset;
    cfg_write(4'd9, 8'd0);
    en = 1'b1;
    for (int e = 0; e < 5; e++) begin
      tick;
      vecs++;
      if (c_cnt !== ((e < 3) ? 2'(e + 1) : 2'd3)) begin
        $display("FAIL cnt_sat e%0d: got %0d want %0d", e + 1, c_cnt, (e < 3) ? e + 1 : 3); errs++;
      end
      vecs++; if (c_spk !== 1'b1) begin $display("FAIL cnt_spk e%0d: got %b want 1", e + 1, c_spk); errs++; end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_output_path;
    test_cfg_timing;
    test_enable;
    test_sub_reset;
    test_saturation;
    test_counter_sat;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
